// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   state_t  : loader FSM encoding
//   NOP_WORD : RV32I ADDI x0,x0,0, the default tail-fill word
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_HOLD = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream boot channel (valid/ready handshake).
//   s_valid : byte available (master -> slave)
//   s_data  : byte value     (master -> slave)
//   s_ready : byte accepted when s_valid & s_ready (slave -> master)
interface imem_boot_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/imem_boot_loader_ram.sv
// WORDS x 32 instruction RAM: one synchronous write port, one asynchronous read port.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write word address
//   i_wdata : write data
//   i_raddr : read word address
//   o_rdata : mem[i_raddr], combinational
module imem_boot_loader_ram #(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with hardware program loader. Packs a little-endian byte
// stream into 32-bit words, optionally fills the unloaded tail with FILL_WORD,
// holds the core in reset for a few cycles, then releases it.
//   clk, reset    : clock, synchronous active-high reset
//   i_start       : one-cycle load request (honoured in IDLE and RUN)
//   i_len_words   : words to load, clipped to WORDS, sampled with i_start
//   s_bus         : byte stream (slave side)
//   i_im_addr     : core word address
//   o_im_data     : mem[i_im_addr], combinational
//   o_core_resetb : active-low core reset, registered
//   o_busy        : LOAD/FILL/HOLD
//   o_done        : RUN
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int          WORDS          = 1024,
    parameter int          ADDR_W         = $clog2(WORDS),
    parameter int          FILL_EN        = 1,
    parameter logic [31:0] FILL_WORD      = NOP_WORD,
    parameter int          RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len_words,
    imem_boot_loader_if.slave s_bus,
    input  logic [ADDR_W-1:0] i_im_addr,
    output logic [31:0]       o_im_data,
    output logic              o_core_resetb,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PW     = ADDR_W + 1;
    localparam int HOLD_W = (RELEASE_CYCLES < 1) ? 1 : $clog2(RELEASE_CYCLES + 1);

    state_t            r_state, w_state_n;
    logic [PW-1:0]     r_len, w_len_n;
    logic [PW-1:0]     r_wptr, w_wptr_n;
    logic [1:0]        r_lane, w_lane_n;
    logic [HOLD_W-1:0] r_hold, w_hold_n;
    logic [23:0]       r_stage;
    logic              r_core_resetb;

    logic [PW-1:0]     w_len_clip;
    logic              w_ready;
    logic              w_accept;
    logic              w_we;
    logic [31:0]       w_wdata;

    assign w_len_clip = (i_len_words > PW'(WORDS)) ? PW'(WORDS) : i_len_words;
    assign w_accept   = w_ready & s_bus.s_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_wptr        <= '0;
            r_lane        <= '0;
            r_hold        <= '0;
            r_core_resetb <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_len         <= w_len_n;
            r_wptr        <= w_wptr_n;
            r_lane        <= w_lane_n;
            r_hold        <= w_hold_n;
            // Equals (state == RUN) but comes straight off a flop.
            r_core_resetb <= (w_state_n == S_RUN);
        end
    end

    // Bytes 0..2 wait here; byte 3 is merged straight into the RAM write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage <= '0;
        end else if (w_accept) begin
            unique case (r_lane)
                2'd0:    r_stage[7:0]   <= s_bus.s_data;
                2'd1:    r_stage[15:8]  <= s_bus.s_data;
                2'd2:    r_stage[23:16] <= s_bus.s_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_len_n   = r_len;
        w_wptr_n  = r_wptr;
        w_lane_n  = r_lane;
        w_hold_n  = r_hold;
        w_ready   = 1'b0;
        w_we      = 1'b0;
        w_wdata   = FILL_WORD;
        unique case (r_state)
            S_IDLE, S_RUN: begin
                if (i_start) begin
                    w_len_n  = w_len_clip;
                    w_wptr_n = '0;
                    w_lane_n = '0;
                    w_hold_n = '0;
                    if (w_len_clip != '0)  w_state_n = S_LOAD;
                    else if (FILL_EN != 0) w_state_n = S_FILL;
                    else                   w_state_n = S_HOLD;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (s_bus.s_valid) begin
                    w_lane_n = r_lane + 2'd1;
                    if (r_lane == 2'd3) begin
                        w_we     = 1'b1;
                        w_wdata  = {s_bus.s_data, r_stage};
                        w_wptr_n = r_wptr + PW'(1);
                        if (r_wptr == r_len - PW'(1)) begin
                            w_hold_n  = '0;
                            w_state_n = ((FILL_EN != 0) && (r_len < PW'(WORDS))) ? S_FILL : S_HOLD;
                        end
                    end
                end
            end
            S_FILL: begin
                w_we     = 1'b1;
                w_wptr_n = r_wptr + PW'(1);
                if (r_wptr == PW'(WORDS - 1)) begin
                    w_hold_n  = '0;
                    w_state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                // RELEASE_CYCLES+1 cycles in HOLD, so 0 still moves on at the next edge.
                if (r_hold == HOLD_W'(RELEASE_CYCLES)) w_state_n = S_RUN;
                else                                   w_hold_n  = r_hold + HOLD_W'(1);
            end
            default: w_state_n = S_IDLE;
        endcase
        // Reset overrides any write scheduled for this edge.
        if (reset) w_we = 1'b0;
    end

    imem_boot_loader_ram #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr[ADDR_W-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (i_im_addr),
        .o_rdata (o_im_data)
    );

    assign s_bus.s_ready = w_ready;
    assign o_core_resetb = r_core_resetb;
    assign o_busy        = (r_state == S_LOAD) || (r_state == S_FILL) || (r_state == S_HOLD);
    assign o_done        = (r_state == S_RUN);

endmodule
